word_order_packer: RTL
======================

WORD_ORDER_PACKER -- requirements
Module: word_order_packer

Interface
REQ-001 SHALL have parameter PAD_BYTE, default 8'h00: fill value for unused byte lanes of a flushed partial word.
REQ-002 SHALL have parameter BIG_ENDIAN, default 1: 1 places the first arriving byte in bits [31:24]; 0 places it in bits [7:0].
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port swap_en  input  1  1 = apply nibble swap to each byte of the word (byte {b7..b0} becomes {b3,b2,b1,b0,b7,b6,b5,b4}).
REQ-006 SHALL have port byte_valid  input  1  upstream byte present.
REQ-007 SHALL have port byte_data  input  8  upstream byte.
REQ-008 SHALL have port byte_ready  output  1  packer accepts byte this cycle.
REQ-009 SHALL have port flush  input  1  single-cycle request to emit the current partial word.
REQ-010 SHALL have port word_valid  output  1  packed word available.
REQ-011 SHALL have port word_data  output  32  packed word.
REQ-012 SHALL have port word_bytes  output  3  count of real bytes in word_data, 1..4.
REQ-013 SHALL have port word_ready  input  1  downstream accepts word this cycle.
REQ-014 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 SHALL accept a byte only when byte_valid and byte_ready are both high on the same edge.
REQ-016 SHALL implement states IDLE (0 bytes held), FILL (1..3 bytes held) and OUT (word held, word_valid=1).
REQ-017 SHALL drive byte_ready=1 in IDLE and FILL and byte_ready=0 in OUT; maximum throughput is 4 bytes per 5 cycles.
REQ-018 SHALL sample swap_en on acceptance of the first byte of a word and apply that value to all bytes of that word; swap_en changes mid-word are ignored.
REQ-019 SHALL store byte k (arrival index 0..3) in lane [31-8k -: 8] when BIG_ENDIAN=1, else in lane [8k +: 8], post-swap if enabled.
REQ-020 IDLE: accepted byte -> FILL with count=1; flush ignored.
REQ-021 FILL: accepted byte with count<3 -> count+1, remain in FILL; accepted byte with count=3 -> OUT, word_bytes=4, one cycle after the 4th acceptance.
REQ-022 FILL: flush with no byte accepted -> OUT, word_bytes=count, unfilled lanes = PAD_BYTE (never swapped).
REQ-023 FILL: flush and byte accepted on the same edge -> byte stored first, then OUT with word_bytes=count+1 (4 if the word completes).
REQ-024 OUT: word_data and word_bytes SHALL hold stable until word_valid and word_ready are both high; that edge -> IDLE, count=0.
REQ-025 OUT: flush SHALL be ignored and not remembered.
REQ-026 word_valid SHALL be registered, with no combinational path from word_ready or byte_valid to any output.
REQ-027 word_data lanes SHALL be cleared to PAD_BYTE when a new word begins, so a short word never carries stale bytes.

Reset
REQ-028 On a clk edge with rst_n=0 SHALL go to IDLE with count=0, word_valid=0, word_data=32'h0, word_bytes=0, busy=0 and byte_ready=1 from the following cycle.
REQ-029 Reset in FILL or OUT SHALL discard held bytes and the pending word without emitting them.
REQ-030 Inputs SHALL be ignored on any edge where rst_n=0.

Verification
REQ-031 BIG_ENDIAN=1, swap_en=0, bytes 12,34,56,78 back-to-back -> word_data=32'h12345678, word_bytes=4, word_valid one cycle after the 4th byte.
REQ-032 swap_en=1 at the first byte, bytes 12,34,56,78, swap_en dropped after the first byte -> word_data=32'h21436587.
REQ-033 Bytes A5,3C then flush, PAD_BYTE=00 -> word_data=32'hA53C0000, word_bytes=2; BIG_ENDIAN=0 -> 32'h00003CA5.
REQ-034 3 bytes held, 4th byte (DE) and flush on the same edge -> word_bytes=4 with DE in the last lane; a single word only.
REQ-035 word_ready held low 10 cycles in OUT -> word_data stable, byte_ready=0 throughout; flush pulsed meanwhile -> no extra word after the handshake.
REQ-036 rst_n=0 asserted with 2 bytes held -> next cycle busy=0, word_valid=0; 4 new bytes -> word contains only the new bytes.

Source files
------------

// File: rtl/word_order_packer.sv
// word_order_packer: packs an 8-bit byte stream into 32-bit words.
// Supports flush of partial words, lane padding and nibble swap.
module word_order_packer #(
    parameter logic [7:0] PAD_BYTE   = 8'h00,
    parameter bit         BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        swap_en,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    input  logic        flush,
    output logic        word_valid,
    output logic [31:0] word_data,
    output logic [2:0]  word_bytes,
    input  logic        word_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [2:0]  count;
    logic [2:0]  count_n;
    logic [31:0] data_q;
    logic [31:0] data_n;
    logic [2:0]  bytes_q;
    logic [2:0]  bytes_n;
    logic        swap_q;
    logic        swap_n;
    logic        valid_q;

    logic        acc;
    logic        sel_swap;
    logic [7:0]  in_byte;

    function automatic logic [7:0] nib_swap(
        input logic [7:0] b
    );
        return {b[3:0], b[7:4]};
    endfunction

    // Lane for arrival index k depends on the configured byte order.
    function automatic logic [31:0] put_lane(
        input logic [31:0] w,
        input logic [1:0]  k,
        input logic [7:0]  b
    );
        logic [31:0] r;
        logic [1:0]  lane;
        r    = w;
        lane = BIG_ENDIAN ? (2'd3 - k) : k;
        unique case (lane)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

    // The first byte of a word uses the live swap_en; later bytes
    // reuse the value captured with that first byte.
    always_comb begin
        acc      = byte_valid & (state != OUT);
        sel_swap = (state == IDLE) ? swap_en : swap_q;
        in_byte  = sel_swap ? nib_swap(byte_data) : byte_data;
    end

    // Next-state and datapath update for the three-state packer.
    always_comb begin
        state_n = state;
        count_n = count;
        data_n  = data_q;
        bytes_n = bytes_q;
        swap_n  = swap_q;
        unique case (state)
            IDLE: begin
                if (acc) begin
                    swap_n  = swap_en;
                    data_n  = put_lane({4{PAD_BYTE}},
                                       2'd0, in_byte);
                    count_n = 3'd1;
                    state_n = FILL;
                end
            end
            FILL: begin
                if (acc) begin
                    data_n = put_lane(data_q, count[1:0],
                                      in_byte);
                    if (count == 3'd3 || flush) begin
                        state_n = OUT;
                        bytes_n = count + 3'd1;
                        count_n = 3'd0;
                    end else begin
                        count_n = count + 3'd1;
                    end
                end else if (flush) begin
                    state_n = OUT;
                    bytes_n = count;
                    count_n = 3'd0;
                end
            end
            OUT: begin
                if (word_ready) begin
                    state_n = IDLE;
                    count_n = 3'd0;
                    bytes_n = 3'd0;
                end
            end
            default: begin
                state_n = IDLE;
                count_n = 3'd0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= 3'd0;
            data_q  <= 32'h0;
            bytes_q <= 3'd0;
            swap_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            data_q  <= data_n;
            bytes_q <= bytes_n;
            swap_q  <= swap_n;
            valid_q <= (state_n == OUT);
        end
    end

    // Outputs come straight from registers only.
    always_comb begin
        word_valid = valid_q;
        byte_ready = ~valid_q;
        word_data  = data_q;
        word_bytes = bytes_q;
        busy       = (state != IDLE);
    end

endmodule
